codec_cfg_ctrl: RTL and testbench



---
 rtl/codec_cfg_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_codec_cfg_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/codec_cfg_ctrl.sv
// Codec power-up sequencer: waits for the codec, enters SPI mode with three latch
// pulses, then writes every ROM entry as a 32-bit SPI frame and raises port_en.
module codec_cfg_ctrl #(
  parameter int CLK_DIV     = 4,
  parameter int N_WORDS     = 16,
  parameter int ROM_AW      = 6,
  parameter int WAIT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic              cclk,
  output logic              clatch_n,
  output logic              cdata,
  output logic              busy,
  output logic              done,
  output logic              port_en
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [TW-1:0]     TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [WW-1:0]     WAIT_LAST = WW'(WAIT_CYCLES - 1);
  localparam logic [ROM_AW-1:0] LAST_WORD = ROM_AW'(N_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, PWR_WAIT, SPI_ENTER, FETCH, SETUP, SHIFT, HOLD, GAP, FIN
  } state_t;

  state_t            state_reg, state_next;
  logic [TW-1:0]     tick_cnt_reg, tick_cnt_next;
  logic [WW-1:0]     wait_cnt_reg, wait_cnt_next;
  logic [5:0]        phase_reg, phase_next;
  logic [ROM_AW-1:0] word_idx_reg, word_idx_next;
  logic [31:0]       shreg_reg, shreg_next;
  logic              fetch_wait_reg, fetch_wait_next;
  logic              cclk_reg, cclk_next;
  logic              clatch_n_reg, clatch_n_next;
  logic              cdata_reg, cdata_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              timed;
  logic              tick;

  // Tick-timed states only; the counter is held at zero elsewhere so every
  // timed state begins on a full tick and frame timing is exact for any CLK_DIV.
  assign timed = (state_reg == SPI_ENTER) || (state_reg == SETUP) || (state_reg == SHIFT) ||
                 (state_reg == HOLD) || (state_reg == GAP);
  assign tick  = timed && (tick_cnt_reg == TICK_LAST);

  always_comb begin
    state_next      = state_reg;
    wait_cnt_next   = wait_cnt_reg;
    phase_next      = phase_reg;
    word_idx_next   = word_idx_reg;
    shreg_next      = shreg_reg;
    fetch_wait_next = fetch_wait_reg;
    busy_next       = busy_reg;
    done_next       = done_reg;
    tick_cnt_next   = (tick || !timed) ? '0 : tick_cnt_reg + TW'(1);

    case (state_reg)
      IDLE, FIN: begin
        state_next = IDLE;
        if (start) begin
          state_next    = PWR_WAIT;
          wait_cnt_next = '0;
          word_idx_next = '0;
          busy_next     = 1'b1;
          done_next     = 1'b0;
        end
      end
      PWR_WAIT: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          state_next = SPI_ENTER;
          phase_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + WW'(1);
        end
      end
      SPI_ENTER: begin
        if (tick) begin
          if (phase_reg == 6'd5) begin
            state_next      = FETCH;
            fetch_wait_next = 1'b0;
          end else begin
            phase_next = phase_reg + 6'd1;
          end
        end
      end
      FETCH: begin
        // First cycle lets the synchronous ROM respond to the new address.
        if (!fetch_wait_reg) begin
          fetch_wait_next = 1'b1;
        end else begin
          shreg_next = {8'h00, rom_data};
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          state_next = SHIFT;
          phase_next = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (phase_reg == 6'd63) begin
            state_next = HOLD;
          end else begin
            phase_next = phase_reg + 6'd1;
            if (phase_reg[0]) shreg_next = {shreg_reg[30:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_next = GAP;
          phase_next = '0;
        end
      end
      GAP: begin
        if (tick) begin
          if (phase_reg == 6'd1) begin
            if (word_idx_reg < LAST_WORD) begin
              word_idx_next   = word_idx_reg + ROM_AW'(1);
              fetch_wait_next = 1'b0;
              state_next      = FETCH;
            end else begin
              state_next = FIN;
              done_next  = 1'b1;
              busy_next  = 1'b0;
            end
          end else begin
            phase_next = phase_reg + 6'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Pin values are decoded from the next state and registered, so the pins are glitch-free.
    clatch_n_next = !(((state_next == SPI_ENTER) && !phase_next[0]) || (state_next == SETUP) ||
                      (state_next == SHIFT) || (state_next == HOLD));
    cclk_next     = (state_next == SHIFT) && phase_next[0];
    cdata_next    = ((state_next == SETUP) || (state_next == SHIFT)) ? shreg_next[31] : cdata_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      tick_cnt_reg   <= '0;
      wait_cnt_reg   <= '0;
      phase_reg      <= '0;
      word_idx_reg   <= '0;
      shreg_reg      <= '0;
      fetch_wait_reg <= 1'b0;
      cclk_reg       <= 1'b0;
      clatch_n_reg   <= 1'b1;
      cdata_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tick_cnt_reg   <= tick_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      phase_reg      <= phase_next;
      word_idx_reg   <= word_idx_next;
      shreg_reg      <= shreg_next;
      fetch_wait_reg <= fetch_wait_next;
      cclk_reg       <= cclk_next;
      clatch_n_reg   <= clatch_n_next;
      cdata_reg      <= cdata_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  assign rom_addr = word_idx_reg;
  assign cclk     = cclk_reg;
  assign clatch_n = clatch_n_reg;
  assign cdata    = cdata_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign port_en  = done_reg;

endmodule

// File: tb/tb_codec_cfg_ctrl.sv
// Bench for codec_cfg_ctrl: a one-word and a three-word instance with CLK_DIV=2,
// WAIT_CYCLES=8; a monitor decodes SPI frames and checks them against a scoreboard queue.
module tb_codec_cfg_ctrl;

  typedef struct packed {
    logic [31:0] word;
    logic [5:0]  addr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start1, start3;
  logic [5:0]  rom_addr1, rom_addr3;
  logic [23:0] rom_data1, rom_data3;
  logic        cclk1, clatch_n1, cdata1, busy1, done1, port_en1;
  logic        cclk3, clatch_n3, cdata3, busy3, done3, port_en3;
  logic        sel;

  logic [23:0] rom_mem [0:63];
  logic [31:0] exp_words [0:2];
  exp_t        exp_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          mon_bits, mon_frames, enter_pulses, rises_total;

  codec_cfg_ctrl #(.CLK_DIV(2), .N_WORDS(1), .ROM_AW(6), .WAIT_CYCLES(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .cclk(cclk1), .clatch_n(clatch_n1), .cdata(cdata1), .busy(busy1), .done(done1),
    .port_en(port_en1)
  );

  codec_cfg_ctrl #(.CLK_DIV(2), .N_WORDS(3), .ROM_AW(6), .WAIT_CYCLES(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .rom_addr(rom_addr3), .rom_data(rom_data3),
    .cclk(cclk3), .clatch_n(clatch_n3), .cdata(cdata3), .busy(busy3), .done(done3),
    .port_en(port_en3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = 24'h000000;
    rom_mem[0]   = 24'h400001;
    rom_mem[1]   = 24'h401501;
    rom_mem[2]   = 24'h40F901;
    exp_words[0] = 32'h00400001;
    exp_words[1] = 32'h00401501;
    exp_words[2] = 32'h0040F901;
  end

  always @(posedge clk) begin
    rom_data1 <= rom_mem[rom_addr1];
    rom_data3 <= rom_mem[rom_addr3];
  end

  logic       m_cclk, m_clatch_n, m_cdata, m_busy, m_done, m_port_en;
  logic [5:0] m_rom_addr;
  assign m_cclk     = sel ? cclk3     : cclk1;
  assign m_clatch_n = sel ? clatch_n3 : clatch_n1;
  assign m_cdata    = sel ? cdata3    : cdata1;
  assign m_busy     = sel ? busy3     : busy1;
  assign m_done     = sel ? done3     : done1;
  assign m_port_en  = sel ? port_en3  : port_en1;
  assign m_rom_addr = sel ? rom_addr3 : rom_addr1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame monitor: samples on the falling clk edge, decodes latch windows.
  initial begin
    int          low_len;
    logic        prev_cclk;
    logic [31:0] word;
    logic [5:0]  addr;
    exp_t        e;
    low_len   = 0;
    prev_cclk = 1'b0;
    word      = '0;
    addr      = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low_len   = 0;
        mon_bits  = 0;
        prev_cclk = 1'b0;
      end else begin
        if (m_cclk && !prev_cclk) begin
          word = {word[30:0], m_cdata};
          mon_bits++;
          rises_total++;
        end
        if (!m_clatch_n) begin
          low_len++;
          if (low_len == 1) addr = m_rom_addr;
        end else if (low_len > 0) begin
          if (mon_bits == 0) begin
            enter_pulses++;
          end else if (exp_q.size() == 0) begin
            check("unexpected_frame", word, 32'h0);
            n_errors += (word == 32'h0) ? 1 : 0;
          end else begin
            e = exp_q.pop_front();
            $display("frame %0d: word=%08h addr=%0d bits=%0d low=%0d", mon_frames, word, addr,
                     mon_bits, low_len);
            check("frame_word", word, e.word);
            check("frame_addr", 32'(addr), 32'(e.addr));
            check("frame_bits", 32'(mon_bits), 32'd32);
            check("latch_low_clks", 32'(low_len), 32'd132);
            check("done_before_last_gap", 32'(m_done), 32'd0);
            mon_frames++;
          end
          low_len  = 0;
          mon_bits = 0;
        end
        prev_cclk = m_cclk;
      end
    end
  end

  task automatic set_start(input logic v);
    start1 = sel ? 1'b0 : v;
    start3 = sel ? v : 1'b0;
  endtask

  task automatic run_seq(input int nw, input int exp_cyc, input bit pulse_busy, input string tag);
    int cyc;
    bit pulsed;
    enter_pulses = 0;
    rises_total  = 0;
    mon_frames   = 0;
    pulsed       = 1'b0;
    for (int i = 0; i < nw; i++) exp_q.push_back('{word: exp_words[i], addr: 6'(i)});
    @(posedge clk); #1 set_start(1'b1);
    @(posedge clk); #1 set_start(1'b0);
    check({tag, "_busy_after_start"}, 32'(m_busy), 32'd1);
    check({tag, "_done_after_start"}, 32'(m_done), 32'd0);
    check({tag, "_port_en_after_start"}, 32'(m_port_en), 32'd0);
    cyc = 0;
    while (!m_done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (pulsed) set_start(1'b0);
      if (pulse_busy && !pulsed && mon_bits == 5) begin
        set_start(1'b1);
        pulsed = 1'b1;
      end
    end
    set_start(1'b0);
    $display("%s: done after %0d clk, %0d cclk rises", tag, cyc, rises_total);
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_port_en"}, 32'(m_port_en), 32'd1);
    check({tag, "_busy_end"}, 32'(m_busy), 32'd0);
    check({tag, "_enter_pulses"}, 32'(enter_pulses), 32'd3);
    check({tag, "_cclk_rises"}, 32'(rises_total), 32'(32 * nw));
    check({tag, "_frames_left"}, 32'(exp_q.size()), 32'd0);
    repeat (5) @(posedge clk);
    #1 check({tag, "_done_sticky"}, 32'(m_done), 32'd1);
  endtask

  initial begin
    int bad;
    int cnt;
    rst_n = 1'b0;
    sel   = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_rom_addr", 32'(rom_addr3), 32'd0);
    check("rst_cclk", 32'(cclk3), 32'd0);
    check("rst_clatch_n", 32'(clatch_n3), 32'd1);
    check("rst_cdata", 32'(cdata3), 32'd0);
    check("rst_busy", 32'(busy3), 32'd0);
    check("rst_done", 32'(done3), 32'd0);
    check("rst_port_en", 32'(port_en3), 32'd0);
    check("rst_dut1_outs", {26'd0, cclk1, clatch_n1, cdata1, busy1, done1, port_en1}, 32'h10);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (cclk1 || !clatch_n1 || cclk3 || !clatch_n3 || busy3 || done3) bad++;
    end
    check("idle_1000_clk", 32'(bad), 32'd0);

    sel = 1'b0;
    run_seq(1, 158, 1'b0, "single_word");
    run_seq(1, 158, 1'b1, "start_while_busy");

    sel = 1'b1;
    run_seq(3, 434, 1'b0, "table_walk");
    run_seq(3, 434, 1'b0, "restart_after_done");

    for (int i = 0; i < 3; i++) exp_q.push_back('{word: exp_words[i], addr: 6'(i)});
    mon_frames = 0;
    @(posedge clk); #1 set_start(1'b1);
    @(posedge clk); #1 set_start(1'b0);
    cnt = 0;
    while (!(mon_frames == 1 && mon_bits == 10) && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("rst_mid_reached", 32'(cnt < 2000), 32'd1);
    check("rst_mid_latch_low", 32'(clatch_n3), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_clatch_n", 32'(clatch_n3), 32'd1);
    check("rst_mid_cclk", 32'(cclk3), 32'd0);
    check("rst_mid_busy", 32'(busy3), 32'd0);
    check("rst_mid_rom_addr", 32'(rom_addr3), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_seq(3, 434, 1'b0, "rerun_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
